// File: rtl/tl_egress_drain_pkg.sv
// ------------------------------------------------------------------
// tl_egress_drain_pkg : shared widths, FSM encodings and word type
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package tl_egress_drain_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int CNT_WIDTH  = 5;
  localparam int NUM_CLASS  = 4;
  localparam int CLS_WIDTH  = 2;
  localparam int BUF_DEPTH  = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;

  typedef struct packed {
    logic [CLS_WIDTH-1:0]  cls;
    logic [DATA_WIDTH-1:0] data;
  } egress_word_t;

endpackage

`default_nettype wire

// File: rtl/tl_skid_fifo2.sv
// ------------------------------------------------------------------
// tl_skid_fifo2 : 2-entry word+class FIFO with occupancy count
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tl_skid_fifo2
  import tl_egress_drain_pkg::*;
(
  input  logic         clk,
  input  logic         reset_L,
  input  logic         push_i,
  input  egress_word_t push_word_i,
  input  logic         pop_i,
  output egress_word_t head_o,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         empty_o
);

  egress_word_t mem_q [BUF_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  // Callers qualify push/pop, so a simultaneous push and pop is always legal.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_word_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

`default_nettype wire

// File: rtl/tl_egress_drain.sv
// ------------------------------------------------------------------
// tl_egress_drain : round-robin drain of four class FIFOs onto one stream
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tl_egress_drain
  import tl_egress_drain_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic                  empty2,
  input  logic                  empty3,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic                  pop0,
  output logic                  pop1,
  output logic                  pop2,
  output logic                  pop3,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CLS_WIDTH-1:0]  out_class,
  input  logic [CLS_WIDTH-1:0]  cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_out,
  output logic                  idle
);

  logic [NUM_CLASS-1:0]  w_empty;
  logic [DATA_WIDTH-1:0] w_data_in [NUM_CLASS];

  logic [1:0]           rr_q, rr_d;
  logic                 inflight_q, inflight_d;
  logic [CLS_WIDTH-1:0] inflight_cls_q, inflight_cls_d;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CLASS];

  logic                 w_found;
  logic [1:0]           w_grant;
  logic [1:0]           w_occ;
  logic                 w_credit;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_out_fire;
  egress_word_t         w_push_word;
  egress_word_t         w_head;
  logic [1:0]           w_buf_count;
  logic                 w_buf_full;
  logic                 w_buf_empty;

  assign w_empty      = {empty3, empty2, empty1, empty0};
  assign w_data_in[0] = data_in0;
  assign w_data_in[1] = data_in1;
  assign w_data_in[2] = data_in2;
  assign w_data_in[3] = data_in3;

  always_comb begin
    logic [1:0] idx;
    idx     = rr_q;
    w_found = 1'b0;
    w_grant = rr_q;
    for (int i = 0; i < NUM_CLASS; i++) begin
      idx = rr_q + i[1:0];
      if (!w_found && !w_empty[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  // Credit counts the word already popped but not yet captured.
  assign w_occ    = w_buf_count + {1'b0, inflight_q};
  assign w_credit = (w_occ < 2'd2);
  assign w_pop    = reset_L & enable & w_found & w_credit;

  assign {pop3, pop2, pop1, pop0} = w_pop ? (4'b0001 << w_grant) : 4'b0000;

  assign w_out_fire       = out_valid & out_ready;
  assign w_push           = inflight_q & (~w_buf_full | w_out_fire);
  assign w_push_word.cls  = inflight_cls_q;
  assign w_push_word.data = w_data_in[inflight_cls_q];

  tl_skid_fifo2 u_skid (
    .clk         (clk),
    .reset_L     (reset_L),
    .push_i      (w_push),
    .push_word_i (w_push_word),
    .pop_i       (w_out_fire),
    .head_o      (w_head),
    .count_o     (w_buf_count),
    .full_o      (w_buf_full),
    .empty_o     (w_buf_empty)
  );

  assign out_valid = ~w_buf_empty;
  assign data_out  = w_head.data;
  assign out_class = w_head.cls;

  assign rr_d           = w_pop ? (w_grant + 2'd1) : rr_q;
  assign inflight_d     = w_pop;
  assign inflight_cls_d = w_pop ? w_grant : inflight_cls_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_pop) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_occ == 2'd2) begin
          state_d = ST_STALL;
        end else if (!w_pop && !inflight_q && (w_buf_count == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (w_credit) state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      rr_q           <= 2'd0;
      inflight_q     <= 1'b0;
      inflight_cls_q <= '0;
      state_q        <= ST_IDLE;
      for (int i = 0; i < NUM_CLASS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q           <= rr_d;
      inflight_q     <= inflight_d;
      inflight_cls_q <= inflight_cls_d;
      state_q        <= state_d;
      if (w_out_fire) begin
        cnt_q[out_class] <= cnt_q[out_class] + CNT_WIDTH'(1);
      end
    end
  end

  assign cnt_out = cnt_q[cnt_sel];
  assign idle    = (state_q == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tl_egress_drain.sv
// ------------------------------------------------------------------
// tb_tl_egress_drain : directed self-checking bench for tl_egress_drain
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_tl_egress_drain;
  import tl_egress_drain_pkg::*;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        enable;
  logic [3:0]  emp;
  logic [11:0] din [4];
  logic        pop0, pop1, pop2, pop3;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] data_out;
  logic [1:0]  out_class;
  logic [1:0]  cnt_sel;
  logic [4:0]  cnt_out;
  logic        idle;

  always #5 clk = ~clk;

  tl_egress_drain dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .enable    (enable),
    .empty0    (emp[0]),
    .empty1    (emp[1]),
    .empty2    (emp[2]),
    .empty3    (emp[3]),
    .data_in0  (din[0]),
    .data_in1  (din[1]),
    .data_in2  (din[2]),
    .data_in3  (din[3]),
    .pop0      (pop0),
    .pop1      (pop1),
    .pop2      (pop2),
    .pop3      (pop3),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .out_class (out_class),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .idle      (idle)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          seq [4];
  logic [13:0] exp_q [$];

  logic [3:0]  s_pop;
  logic        s_valid;
  logic [11:0] s_data;
  logic [1:0]  s_cls;
  logic        s_idle;
  logic [4:0]  s_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO word k of class c: class in the top bits, distinct payload below.
  function automatic logic [11:0] word(input int c, input int n);
    logic [1:0] cc;
    cc = c[1:0];
    return {cc, 10'(n * 3 + 5)};
  endfunction

  // One clock: sample at negedge, score outputs, then present popped data.
  task automatic cyc();
    logic [3:0]  p;
    logic [13:0] e;
    @(negedge clk);
    s_pop   = {pop3, pop2, pop1, pop0};
    s_valid = out_valid;
    s_data  = data_out;
    s_cls   = out_class;
    s_idle  = idle;
    s_cnt   = cnt_out;
    p       = 4'b0000;
    if (!reset_L) begin
      exp_q.delete();
    end else begin
      check("pop_onehot", 32'($onehot0(s_pop)), 32'd1);
      p = s_pop;
      for (int k = 0; k < 4; k++) begin
        if (p[k]) exp_q.push_back({2'(k), word(k, seq[k])});
      end
      if (s_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_class", 32'(s_cls), 32'(e[13:12]));
          check("sb_data", 32'(s_data), 32'(e[11:0]));
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (p[k]) begin
        din[k] = word(k, seq[k]);
        seq[k]++;
      end
    end
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    enable  = 1'b0;
    repeat (2) cyc();
    for (int k = 0; k < 4; k++) begin
      seq[k] = 0;
      din[k] = 12'h000;
    end
    reset_L = 1'b1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      cyc();
      if (s_idle) done = 1'b1;
    end
    check("drain_to_idle", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   npop;
    int   gi;
    bit   found;
    int   gseq [4];

    reset_L   = 1'b0;
    enable    = 1'b0;
    emp       = 4'hF;
    out_ready = 1'b0;
    cnt_sel   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      din[k] = 12'h000;
      seq[k] = 0;
    end

    // Latency after reset, then back-pressure until the buffer fills
    do_reset();
    emp = 4'h0; enable = 1'b1; out_ready = 1'b0;
    cyc();
    check("t1_pop0", 32'(s_pop), 32'h1);
    check("t1_idle_first", 32'(s_idle), 32'd1);
    cyc();
    check("t1_valid_early", 32'(s_valid), 32'd0);
    check("t1_busy", 32'(s_idle), 32'd0);
    check("t1_pop1", 32'(s_pop), 32'h2);
    cyc();
    check("t1_valid", 32'(s_valid), 32'd1);
    check("t1_class", 32'(s_cls), 32'd0);
    check("t1_data", 32'(s_data), 32'h005);
    check("t3_no_pop_full", 32'(s_pop), 32'h0);
    repeat (4) begin
      cyc();
      check("t3_no_pop", 32'(s_pop), 32'h0);
      check("t3_hold_data", 32'(s_data), 32'h005);
      check("t3_hold_class", 32'(s_cls), 32'd0);
    end
    check("t3_stall_state", 32'(dut.state_q), 32'(ST_STALL));
    out_ready = 1'b1;
    npop = 0;
    repeat (12) begin
      cyc();
      if (s_pop != 4'h0) npop++;
    end
    check("t3_resume", 32'(npop > 0), 32'd1);
    enable = 1'b0;
    wait_idle();
    check("t3_all_delivered", 32'(exp_q.size()), 32'd0);

    // Round-robin order with a free-running consumer
    do_reset();
    emp = 4'h0; enable = 1'b1; out_ready = 1'b1;
    gi = 0;
    for (int c = 0; c < 40 && gi < 4; c++) begin
      cyc();
      if (s_pop != 4'h0) begin
        for (int k = 0; k < 4; k++) if (s_pop[k]) gseq[gi] = k;
        gi++;
        if (gi == 4) enable = 1'b0;
      end
    end
    check("t2_grant_count", 32'(gi), 32'd4);
    for (int j = 0; j < 4; j++) check("t2_grant_order", 32'(gseq[j]), 32'(j));
    wait_idle();
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      cyc();
      check("t2_counter", 32'(s_cnt), 32'd1);
    end

    // Pointer parked at 3 after granting class 2
    do_reset();
    emp = 4'b1011; enable = 1'b1; out_ready = 1'b1;
    cyc();
    check("t4_first_grant", 32'(s_pop), 32'h4);
    cyc();
    check("t4_grant_from_ptr3", 32'(s_pop), 32'h4);
    emp = 4'h0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc();
      if (s_pop != 4'h0) begin
        found = 1'b1;
        check("t4_next_is_class3", 32'(s_pop), 32'h8);
      end
    end
    check("t4_pop_seen", 32'(found), 32'd1);
    enable = 1'b0;
    wait_idle();

    // 33 class-1 words: 5-bit counter wraps to 1
    do_reset();
    emp = 4'b1101; enable = 1'b1; out_ready = 1'b1;
    npop = 0;
    for (int c = 0; c < 300 && npop < 33; c++) begin
      cyc();
      if (s_pop[1]) npop++;
      if (npop == 33) enable = 1'b0;
    end
    check("t5_pop_count", 32'(npop), 32'd33);
    wait_idle();
    cnt_sel = 2'd1;
    cyc();
    check("t5_cnt1_wrapped", 32'(s_cnt), 32'd1);
    cnt_sel = 2'd0;
    cyc();
    check("t5_cnt0", 32'(s_cnt), 32'd0);

    // Reset right after a pop drops the in-flight word
    do_reset();
    emp = 4'h0; enable = 1'b1; out_ready = 1'b1;
    repeat (6) cyc();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cyc();
      if (s_pop != 4'h0) found = 1'b1;
    end
    check("t6_pop_before_reset", 32'(found), 32'd1);
    reset_L = 1'b0;
    enable  = 1'b0;
    cyc();
    reset_L = 1'b1;
    cyc();
    check("t6_idle", 32'(s_idle), 32'd1);
    check("t6_valid", 32'(s_valid), 32'd0);
    check("t6_data", 32'(s_data), 32'h000);
    check("t6_class", 32'(s_cls), 32'd0);
    check("t6_pop", 32'(s_pop), 32'h0);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      cyc();
      check("t6_counter", 32'(s_cnt), 32'd0);
      check("t6_no_output", 32'(s_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
